// File: rtl/column_input_ctrl.sv
// column_input_ctrl: player move-entry stage ahead of the column-select FSM.
// Debounces left/right/drop buttons, keeps a column cursor, and issues a
// one-cycle commit (out_column/out_enable) for each legal drop press.
// Optional build macro CURSOR_SKIP_FULL_EN: cursor movement skips full columns
// and the cursor steps off a column that fills after a commit.
module column_input_ctrl #(
    parameter int unsigned NUM_COLS        = 4,
    parameter int unsigned NUM_ROWS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_drop,
    input  logic [15:0] in_gameboard,
    input  logic [1:0]  in_game_status,
    output logic [3:0]  out_column,
    output logic        out_enable,
    output logic [3:0]  cursor,
    output logic        drop_rejected,
    output logic        locked
);

    localparam int unsigned NB       = 3;
    localparam int unsigned BTN_L    = 0;
    localparam int unsigned BTN_R    = 1;
    localparam int unsigned BTN_D    = 2;
    localparam int unsigned TOP_BASE = (NUM_ROWS - 1) * NUM_COLS;

    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DEB_PRE  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       LAST_COL = 4'(NUM_COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COMMIT   = 2'd1,
        S_WAIT_REL = 2'd2,
        S_LOCKED   = 2'd3
    } state_e;

    logic [NB-1:0]    btn_raw;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];
    logic [NB-1:0]    ev_q, ev_d;

    state_e     state_q, state_d;
    logic [3:0] cursor_q, cursor_d;
    logic [3:0] out_column_q, out_column_d;
    logic       out_enable_q, out_enable_d;
    logic       drop_rejected_q, drop_rejected_d;
    logic       locked_q, locked_d;

    logic [15:0] full_vec;
    logic [3:0]  left_tgt, right_tgt;
    logic        game_over;

    // Only the top row decides whether a column is full; the rest of the board
    // is irrelevant to this stage.
    logic unused_board;
    assign unused_board = ^in_gameboard;

    assign btn_raw   = {btn_drop, btn_right, btn_left};
    assign game_over = (in_game_status != 2'b00);

    function automatic logic [3:0] step_left(input logic [3:0] c);
        return (c == 4'd0) ? LAST_COL : c - 4'd1;
    endfunction

    function automatic logic [3:0] step_right(input logic [3:0] c);
        return (c == LAST_COL) ? 4'd0 : c + 4'd1;
    endfunction

`ifdef CURSOR_SKIP_FULL_EN
    // Walk leftwards (with wrap) to the first free column; stay put if none.
    function automatic logic [3:0] seek_left(input logic [3:0] c, input logic [15:0] full);
        logic [3:0] cand;
        logic [3:0] res;
        logic       found;
        cand  = c;
        res   = c;
        found = 1'b0;
        for (int s = 1; s < int'(NUM_COLS); s++) begin
            cand = step_left(cand);
            if (!found && !full[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Walk rightwards (with wrap) to the first free column; stay put if none.
    function automatic logic [3:0] seek_right(input logic [3:0] c, input logic [15:0] full);
        logic [3:0] cand;
        logic [3:0] res;
        logic       found;
        cand  = c;
        res   = c;
        found = 1'b0;
        for (int s = 1; s < int'(NUM_COLS); s++) begin
            cand = step_right(cand);
            if (!found && !full[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction
`endif

    // Per-column full flags taken from the top row of the board.
    always_comb begin
        full_vec = '0;
        for (int i = 0; i < int'(NUM_COLS); i++) begin
            full_vec[i] = in_gameboard[TOP_BASE + i];
        end
    end

    // Cursor movement targets for a left or right event.
    always_comb begin
`ifdef CURSOR_SKIP_FULL_EN
        left_tgt  = seek_left(cursor_q, full_vec);
        right_tgt = seek_right(cursor_q, full_vec);
`else
        left_tgt  = step_left(cursor_q);
        right_tgt = step_right(cursor_q);
`endif
    end

    // Debounce: count stable-high cycles, saturate, fire once on reaching the limit.
    always_comb begin
        for (int i = 0; i < int'(NB); i++) begin
            cnt_d[i] = '0;
            ev_d[i]  = 1'b0;
            if (btn_raw[i]) begin
                cnt_d[i] = (cnt_q[i] == DEB_MAX) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
                ev_d[i]  = (cnt_q[i] == DEB_PRE);
            end
        end
    end

    // Next state and outputs; game over overrides everything, including a commit.
    always_comb begin
        state_d         = state_q;
        cursor_d        = cursor_q;
        out_column_d    = out_column_q;
        out_enable_d    = 1'b0;
        drop_rejected_d = 1'b0;
        locked_d        = game_over;

        if (game_over) begin
            state_d = S_LOCKED;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ev_q[BTN_D]) begin
                        if (full_vec[cursor_q]) begin
                            drop_rejected_d = 1'b1;
                        end else begin
                            state_d      = S_COMMIT;
                            out_enable_d = 1'b1;
                            out_column_d = cursor_q;
                        end
                    end else if (ev_q[BTN_L]) begin
                        cursor_d = left_tgt;
                    end else if (ev_q[BTN_R]) begin
                        cursor_d = right_tgt;
                    end
                end
                S_COMMIT: begin
                    state_d = S_WAIT_REL;
                end
                S_WAIT_REL: begin
`ifdef CURSOR_SKIP_FULL_EN
                    if (full_vec[cursor_q]) begin
                        cursor_d = right_tgt;
                    end
`endif
                    if (!btn_drop) begin
                        state_d = S_IDLE;
                    end
                end
                S_LOCKED: begin
                    state_d = btn_drop ? S_WAIT_REL : S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NB); i++) begin
                cnt_q[i] <= '0;
            end
            ev_q            <= '0;
            state_q         <= S_IDLE;
            cursor_q        <= 4'd0;
            out_column_q    <= 4'd0;
            out_enable_q    <= 1'b0;
            drop_rejected_q <= 1'b0;
            locked_q        <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NB); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ev_q            <= ev_d;
            state_q         <= state_d;
            cursor_q        <= cursor_d;
            out_column_q    <= out_column_d;
            out_enable_q    <= out_enable_d;
            drop_rejected_q <= drop_rejected_d;
            locked_q        <= locked_d;
        end
    end

    assign out_column    = out_column_q;
    assign out_enable    = out_enable_q;
    assign cursor        = cursor_q;
    assign drop_rejected = drop_rejected_q;
    assign locked        = locked_q;

endmodule

// File: tb/tb_column_input_ctrl.sv
// Directed testbench for column_input_ctrl (DEBOUNCE_CYCLES = 16, 4x4 board).
module tb_column_input_ctrl;

    logic        clk;
    logic        reset;
    logic        btn_left;
    logic        btn_right;
    logic        btn_drop;
    logic [15:0] in_gameboard;
    logic [1:0]  in_game_status;
    logic [3:0]  out_column;
    logic        out_enable;
    logic [3:0]  cursor;
    logic        drop_rejected;
    logic        locked;

    int n_checks;
    int n_fail;
    int en_cnt;
    int rej_cnt;

    column_input_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .btn_left       (btn_left),
        .btn_right      (btn_right),
        .btn_drop       (btn_drop),
        .in_gameboard   (in_gameboard),
        .in_game_status (in_game_status),
        .out_column     (out_column),
        .out_enable     (out_enable),
        .cursor         (cursor),
        .drop_rejected  (drop_rejected),
        .locked         (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (out_enable === 1'b1)    en_cnt++;
        if (drop_rejected === 1'b1) rej_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a button for exactly the debounce length, release, let the FSM settle.
    task automatic press(input int which);
        case (which)
            0: btn_left  = 1'b1;
            1: btn_right = 1'b1;
            default: btn_drop = 1'b1;
        endcase
        repeat (16) tick();
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_drop  = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        btn_left       = 1'b0;
        btn_right      = 1'b0;
        btn_drop       = 1'b0;
        in_gameboard   = 16'h0000;
        in_game_status = 2'b00;
        repeat (2) tick();
        n_checks++;
        if ({out_column, out_enable, cursor, drop_rejected, locked} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got col=%0d en=%0b cur=%0d rej=%0b lck=%0b, want all 0",
                     out_column, out_enable, cursor, drop_rejected, locked);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_drop_latency();
        int seen;
        int at;
        seen = 0;
        at   = -1;
        btn_drop = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (out_enable === 1'b1) begin
                seen++;
                at = i;
            end
        end
        n_checks++;
        if (seen != 1) begin
            n_fail++;
            $display("FAIL latency_count: got %0d pulses, want 1", seen);
        end
        n_checks++;
        if (at != 17) begin
            n_fail++;
            $display("FAIL latency_cycle: got pulse at cycle %0d, want 17", at);
        end
        n_checks++;
        if (out_column !== 4'd0) begin
            n_fail++;
            $display("FAIL latency_column: got %0d, want 0", out_column);
        end
        btn_drop = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_cursor_move();
        int en0;
        for (int k = 1; k <= 3; k++) begin
            press(1);
            n_checks++;
            if (cursor !== 4'(k)) begin
                n_fail++;
                $display("FAIL right_step%0d: got cursor %0d, want %0d", k, cursor, k);
            end
        end
        en0 = en_cnt;
        press(2);
        n_checks++;
        if (out_column !== 4'd3 || en_cnt - en0 != 1) begin
            n_fail++;
            $display("FAIL drop_col3: got col=%0d pulses=%0d, want col=3 pulses=1",
                     out_column, en_cnt - en0);
        end
        press(1);
        n_checks++;
        if (cursor !== 4'd0) begin
            n_fail++;
            $display("FAIL right_wrap: got cursor %0d, want 0", cursor);
        end
        press(0);
        n_checks++;
        if (cursor !== 4'd3) begin
            n_fail++;
            $display("FAIL left_wrap: got cursor %0d, want 3", cursor);
        end
    endtask

    task automatic test_glitch();
        int en0;
        int at;
        en0 = en_cnt;
        at  = -1;
        btn_drop = 1'b1;
        repeat (10) tick();
        btn_drop = 1'b0;
        tick();
        btn_drop = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (out_enable === 1'b1 && at < 0) at = i;
            if (i == 10) begin
                n_checks++;
                if (en_cnt != en0) begin
                    n_fail++;
                    $display("FAIL glitch_no_pulse: got %0d pulses, want 0", en_cnt - en0);
                end
            end
        end
        n_checks++;
        if (at != 17) begin
            n_fail++;
            $display("FAIL glitch_restart: got pulse at cycle %0d, want 17", at);
        end
        btn_drop = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reject();
        int en0;
        int rj0;
        press(1);
        press(1);
        n_checks++;
        if (cursor !== 4'd1) begin
            n_fail++;
            $display("FAIL reject_setup: got cursor %0d, want 1", cursor);
        end
        in_gameboard = 16'h2000;
        en0 = en_cnt;
        rj0 = rej_cnt;
        press(2);
        n_checks++;
        if (rej_cnt - rj0 != 1 || en_cnt != en0) begin
            n_fail++;
            $display("FAIL reject_pulse: got rej=%0d en=%0d, want rej=1 en=0",
                     rej_cnt - rj0, en_cnt - en0);
        end
        press(0);
        press(1);
        n_checks++;
`ifdef CURSOR_SKIP_FULL_EN
        if (cursor !== 4'd2) begin
            n_fail++;
            $display("FAIL skip_full: got cursor %0d, want 2", cursor);
        end
`else
        if (cursor !== 4'd1) begin
            n_fail++;
            $display("FAIL no_skip: got cursor %0d, want 1", cursor);
        end
`endif
        in_gameboard = 16'h0000;
        tick();
    endtask

    task automatic test_lockout(input logic [3:0] cur_exp);
        int en0;
        int rj0;
        in_game_status = 2'b01;
        tick();
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL locked_set: got %0b, want 1", locked);
        end
        en0 = en_cnt;
        rj0 = rej_cnt;
        press(0);
        press(1);
        press(2);
        n_checks++;
        if (en_cnt != en0 || rej_cnt != rj0 || cursor !== cur_exp) begin
            n_fail++;
            $display("FAIL locked_ignore: got en=%0d rej=%0d cur=%0d, want 0 0 %0d",
                     en_cnt - en0, rej_cnt - rj0, cursor, cur_exp);
        end
        btn_drop = 1'b1;
        repeat (20) tick();
        in_game_status = 2'b00;
        repeat (20) tick();
        n_checks++;
        if (en_cnt != en0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL unlock_held: got en=%0d locked=%0b, want 0 0", en_cnt - en0, locked);
        end
        btn_drop = 1'b0;
        repeat (2) tick();
        press(2);
        n_checks++;
        if (en_cnt - en0 != 1 || out_column !== cur_exp) begin
            n_fail++;
            $display("FAIL unlock_repress: got en=%0d col=%0d, want 1 %0d",
                     en_cnt - en0, out_column, cur_exp);
        end
    endtask

    task automatic test_reset_in_commit(input logic [3:0] cur_exp);
        btn_drop = 1'b1;
        repeat (17) tick();
        n_checks++;
        if (out_enable !== 1'b1 || out_column !== cur_exp) begin
            n_fail++;
            $display("FAIL commit_before_reset: got en=%0b col=%0d, want 1 %0d",
                     out_enable, out_column, cur_exp);
        end
        reset    = 1'b1;
        btn_drop = 1'b0;
        tick();
        n_checks++;
        if (out_enable !== 1'b0 || cursor !== 4'd0 || out_column !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_in_commit: got en=%0b cur=%0d col=%0d, want 0 0 0",
                     out_enable, cursor, out_column);
        end
        reset = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        logic [3:0] cur_after;
        n_checks = 0;
        n_fail   = 0;
        en_cnt   = 0;
        rej_cnt  = 0;
`ifdef CURSOR_SKIP_FULL_EN
        cur_after = 4'd2;
`else
        cur_after = 4'd1;
`endif
        test_reset();
        test_drop_latency();
        test_cursor_move();
        test_glitch();
        test_reject();
        test_lockout(cur_after);
        test_reset_in_commit(cur_after);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
